// File: rtl/posit_pkg.sv
// Shared sizing helpers and k/regime arithmetic for the PPU posit encoders.
package posit_pkg;

  function automatic int unsigned te_w(input int unsigned n, input int unsigned es);
    return $clog2(n) + es + 2;
  endfunction

  function automatic int unsigned k_w(input int unsigned n, input int unsigned es);
    return te_w(n, es) - es;
  endfunction

  function automatic int unsigned reg_len_w(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

  function automatic int clamp_k(input int k, input int unsigned n);
    int lim;
    lim = int'(n) - 2;
    if (k > lim)  return lim;
    if (k < -lim) return -lim;
    return k;
  endfunction

  function automatic int reg_len(input int k);
    return (k >= 0) ? k + 2 : 1 - k;
  endfunction

endpackage

// File: rtl/posit_pack_pipe_if.sv
// Valid/ready bundle between the PPU arithmetic core and the posit packer.
interface posit_pack_pipe_if #(
  parameter int unsigned N      = 16,
  parameter int unsigned ES     = 1,
  parameter int unsigned FRAC_W = 2 * N
) ();
  import posit_pkg::*;
  localparam int unsigned TE_W = te_w(N, ES);

  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [TE_W-1:0]   in_total_exp;
  logic [FRAC_W-1:0] in_frac_full;
  logic              in_frac_lsb_cut_off;
  logic              in_is_zero;
  logic              in_is_nar;
  logic              in_rnd_mode;
  logic              out_valid;
  logic              out_ready;
  logic [N-1:0]      out_posit;
  logic              out_inexact;
  logic              out_k_oob;

  modport slave (
    input  in_valid, in_sign, in_total_exp, in_frac_full, in_frac_lsb_cut_off,
           in_is_zero, in_is_nar, in_rnd_mode, out_ready,
    output in_ready, out_valid, out_posit, out_inexact, out_k_oob
  );

  modport master (
    output in_valid, in_sign, in_total_exp, in_frac_full, in_frac_lsb_cut_off,
           in_is_zero, in_is_nar, in_rnd_mode, out_ready,
    input  in_ready, out_valid, out_posit, out_inexact, out_k_oob
  );
endinterface

// File: rtl/posit_round_rne.sv
// Final posit rounding: RNE/truncate increment, saturation, sign and special-value override.
module posit_round_rne #(
  parameter int unsigned N = 16
) (
  input  logic [N-2:0] i_body,
  input  logic         i_guard,
  input  logic         i_sticky,
  input  logic         i_rnd_mode,
  input  logic         i_sat_hi,
  input  logic         i_sat_lo,
  input  logic         i_sign,
  input  logic         i_is_zero,
  input  logic         i_is_nar,
  output logic [N-1:0] o_posit,
  output logic         o_inexact,
  output logic         o_k_oob
);
  logic         w_inc;
  logic [N-2:0] w_body_rnd;
  logic [N-1:0] w_mag;

  always_comb begin
    // incrementing an all-ones body would wrap into NaR, so maxpos absorbs it
    w_inc      = ~i_rnd_mode & i_guard & (i_body[0] | i_sticky) & ~(&i_body);
    w_body_rnd = i_body + {{(N-2){1'b0}}, w_inc};
    if (i_sat_hi)      w_mag = {1'b0, {(N-1){1'b1}}};
    else if (i_sat_lo) w_mag = {{(N-1){1'b0}}, 1'b1};
    else               w_mag = {1'b0, w_body_rnd};
    o_posit   = i_sign ? (~w_mag + N'(1)) : w_mag;
    o_inexact = i_guard | i_sticky | i_sat_hi | i_sat_lo;
    o_k_oob   = i_sat_hi | i_sat_lo;
    if (i_is_nar) begin
      o_posit   = {1'b1, {(N-1){1'b0}}};
      o_inexact = 1'b0;
      o_k_oob   = 1'b0;
    end else if (i_is_zero) begin
      o_posit   = '0;
      o_inexact = 1'b0;
      o_k_oob   = 1'b0;
    end
  end
endmodule

// File: rtl/posit_pack_pipe.sv
// Three-stage posit encoder/rounder: decode+clamp, regime assembly+guard/sticky, round+sign.
module posit_pack_pipe
  import posit_pkg::*;
#(
  parameter int unsigned N      = 16,
  parameter int unsigned ES     = 1,
  parameter int unsigned FRAC_W = 2 * N
) (
  input  logic             clk,
  input  logic             rst,
  posit_pack_pipe_if.slave bus
);
  localparam int unsigned K_W       = k_w(N, ES);
  localparam int unsigned REG_LEN_W = reg_len_w(N);
  localparam int unsigned TAIL_W    = ES + FRAC_W;
  localparam int unsigned STR_W     = N + 1 + TAIL_W;

  logic w_en;
  assign w_en         = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = w_en;

  // S1 decode
  logic signed [K_W-1:0]  w_k_raw;
  logic signed [31:0]     w_k_cl;
  logic                   w_sat_hi, w_sat_lo;
  logic [REG_LEN_W-1:0]   w_shamt;
  logic [TAIL_W-1:0]      w_tail;

  assign w_k_raw  = K_W'($signed(bus.in_total_exp) >>> ES);
  assign w_k_cl   = clamp_k(int'(w_k_raw), N);
  assign w_sat_hi = w_k_cl < int'(w_k_raw);
  assign w_sat_lo = w_k_cl > int'(w_k_raw);
  assign w_shamt  = REG_LEN_W'(int'(N) + 1 - reg_len(w_k_cl));

  generate
    if (ES > 0) begin : g_exp
      assign w_tail = {bus.in_total_exp[ES-1:0], bus.in_frac_full};
    end else begin : g_noexp
      assign w_tail = bus.in_frac_full;
    end
  endgenerate

  logic                 r1_valid, r1_sign, r1_kpos, r1_cut, r1_rnd;
  logic                 r1_sat_hi, r1_sat_lo, r1_zero, r1_nar;
  logic [REG_LEN_W-1:0] r1_shamt;
  logic [TAIL_W-1:0]    r1_tail;

  // S2: N regime-polarity bits plus terminator; shifting left leaves reg_len-1 copies on top
  logic [STR_W-1:0] w_str;
  logic [N-2:0]     w_body;
  logic             w_guard, w_sticky;

  assign w_str    = {{N{r1_kpos}}, ~r1_kpos, r1_tail} << r1_shamt;
  assign w_body   = w_str[STR_W-1 -: N-1];
  assign w_guard  = w_str[STR_W-N];
  assign w_sticky = (|w_str[STR_W-N-1:0]) | r1_cut;

  logic         r2_valid, r2_guard, r2_sticky, r2_sign, r2_rnd;
  logic         r2_sat_hi, r2_sat_lo, r2_zero, r2_nar;
  logic [N-2:0] r2_body;

  // S3
  logic [N-1:0] w_posit;
  logic         w_inexact, w_k_oob;

  posit_round_rne #(.N(N)) u_round (
    .i_body     (r2_body),
    .i_guard    (r2_guard),
    .i_sticky   (r2_sticky),
    .i_rnd_mode (r2_rnd),
    .i_sat_hi   (r2_sat_hi),
    .i_sat_lo   (r2_sat_lo),
    .i_sign     (r2_sign),
    .i_is_zero  (r2_zero),
    .i_is_nar   (r2_nar),
    .o_posit    (w_posit),
    .o_inexact  (w_inexact),
    .o_k_oob    (w_k_oob)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_valid <= 1'b0; r1_sign <= 1'b0; r1_kpos <= 1'b0; r1_cut <= 1'b0; r1_rnd <= 1'b0;
      r1_sat_hi <= 1'b0; r1_sat_lo <= 1'b0; r1_zero <= 1'b0; r1_nar <= 1'b0;
      r1_shamt <= '0; r1_tail <= '0;
      r2_valid <= 1'b0; r2_guard <= 1'b0; r2_sticky <= 1'b0; r2_sign <= 1'b0; r2_rnd <= 1'b0;
      r2_sat_hi <= 1'b0; r2_sat_lo <= 1'b0; r2_zero <= 1'b0; r2_nar <= 1'b0;
      r2_body <= '0;
      bus.out_valid <= 1'b0; bus.out_posit <= '0; bus.out_inexact <= 1'b0; bus.out_k_oob <= 1'b0;
    end else if (w_en) begin
      r1_valid  <= bus.in_valid;
      r1_sign   <= bus.in_sign;
      r1_kpos   <= ~w_k_cl[31];
      r1_cut    <= bus.in_frac_lsb_cut_off;
      r1_rnd    <= bus.in_rnd_mode;
      r1_sat_hi <= w_sat_hi;
      r1_sat_lo <= w_sat_lo;
      r1_zero   <= bus.in_is_zero;
      r1_nar    <= bus.in_is_nar;
      r1_shamt  <= w_shamt;
      r1_tail   <= w_tail;

      r2_valid  <= r1_valid;
      r2_body   <= w_body;
      r2_guard  <= w_guard;
      r2_sticky <= w_sticky;
      r2_sign   <= r1_sign;
      r2_rnd    <= r1_rnd;
      r2_sat_hi <= r1_sat_hi;
      r2_sat_lo <= r1_sat_lo;
      r2_zero   <= r1_zero;
      r2_nar    <= r1_nar;

      bus.out_valid   <= r2_valid;
      bus.out_posit   <= w_posit;
      bus.out_inexact <= w_inexact;
      bus.out_k_oob   <= w_k_oob;
    end
  end
endmodule

// File: tb/tb_posit_pack_pipe.sv
// Bench for posit_pack_pipe: directed N=8/ES=0 table, reset flush, randomized streams on N=8/ES=0 and N=16/ES=2.
module tb_posit_pack_pipe;
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  posit_pack_pipe_if #(.N(8),  .ES(0), .FRAC_W(16)) if8  ();
  posit_pack_pipe_if #(.N(16), .ES(2), .FRAC_W(32)) if16 ();

  posit_pack_pipe #(.N(8),  .ES(0), .FRAC_W(16)) dut8  (.clk(clk), .rst(rst), .bus(if8));
  posit_pack_pipe #(.N(16), .ES(2), .FRAC_W(32)) dut16 (.clk(clk), .rst(rst), .bus(if16));

  logic               sel;
  logic               t_in_valid, t_sign, t_cut, t_rnd, t_zero, t_nar, t_out_ready;
  logic signed [31:0] t_te;
  logic [31:0]        t_frac;
  logic               t_in_ready, t_out_valid, t_inex, t_oob;
  logic [15:0]        t_out_posit;

  assign if8.in_valid            = t_in_valid & ~sel;
  assign if8.in_sign             = t_sign;
  assign if8.in_total_exp        = t_te[4:0];
  assign if8.in_frac_full        = t_frac[15:0];
  assign if8.in_frac_lsb_cut_off = t_cut;
  assign if8.in_is_zero          = t_zero;
  assign if8.in_is_nar           = t_nar;
  assign if8.in_rnd_mode         = t_rnd;
  assign if8.out_ready           = sel ? 1'b1 : t_out_ready;

  assign if16.in_valid            = t_in_valid & sel;
  assign if16.in_sign             = t_sign;
  assign if16.in_total_exp        = t_te[7:0];
  assign if16.in_frac_full        = t_frac;
  assign if16.in_frac_lsb_cut_off = t_cut;
  assign if16.in_is_zero          = t_zero;
  assign if16.in_is_nar           = t_nar;
  assign if16.in_rnd_mode         = t_rnd;
  assign if16.out_ready           = sel ? t_out_ready : 1'b1;

  assign t_in_ready  = sel ? if16.in_ready    : if8.in_ready;
  assign t_out_valid = sel ? if16.out_valid   : if8.out_valid;
  assign t_out_posit = sel ? if16.out_posit   : {8'h00, if8.out_posit};
  assign t_inex      = sel ? if16.out_inexact : if8.out_inexact;
  assign t_oob       = sel ? if16.out_k_oob   : if8.out_k_oob;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit sign; int te; logic [31:0] frac; bit cut; bit rnd; bit zero; bit nar;
    logic [15:0] p; bit inex; bit oob;
  } vec_t;

  typedef struct packed { logic [15:0] p; logic inex; logic oob; } exp_t;

  vec_t tbl [22];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: spell out the posit bit string as a queue, then cut, round and negate numerically
  function automatic void model(input int n, input int es, input int fw,
                                input bit sign, input int te, input logic [31:0] frac,
                                input bit cut, input bit rnd, input bit zero, input bit nar,
                                output logic [15:0] p, output bit inex, output bit oob);
    int k, e, base, lim, body;
    bit q[$];
    bit g, st, inc;
    p = '0; inex = 1'b0; oob = 1'b0;
    if (nar) begin p = 16'(1 << (n - 1)); return; end
    if (zero) return;
    base = 1 << es;
    k    = (te >= 0) ? te / base : -((-te + base - 1) / base);
    e    = te - k * base;
    lim  = n - 2;
    if (k > lim) begin
      body = (1 << (n - 1)) - 1; inex = 1'b1; oob = 1'b1;
    end else if (k < -lim) begin
      body = 1; inex = 1'b1; oob = 1'b1;
    end else begin
      if (k >= 0) begin repeat (k + 1) q.push_back(1'b1); q.push_back(1'b0); end
      else        begin repeat (-k)    q.push_back(1'b0); q.push_back(1'b1); end
      for (int i = es - 1; i >= 0; i--) q.push_back(e[i]);
      for (int i = fw - 1; i >= 0; i--) q.push_back(frac[i]);
      body = 0;
      for (int i = 0; i < n - 1; i++) body = body * 2 + int'(q[i]);
      g  = q[n - 1];
      st = cut;
      for (int i = n; i < q.size(); i++) st = st | q[i];
      inc = !rnd && g && ((body % 2 == 1) || st);
      if (inc && body != (1 << (n - 1)) - 1) body++;
      inex = g | st;
    end
    if (sign) body = (1 << n) - body;
    p = 16'(body & ((1 << n) - 1));
  endfunction

  task automatic run_beat(input bit sign, input int te, input logic [31:0] frac,
                          input bit cut, input bit rnd, input bit zero, input bit nar,
                          input logic [15:0] ep, input bit ei, input bit eo, input string nm);
    @(negedge clk);
    t_sign = sign; t_te = te; t_frac = frac; t_cut = cut; t_rnd = rnd;
    t_zero = zero; t_nar = nar; t_in_valid = 1'b1; t_out_ready = 1'b1;
    #1 chk({nm, "_in_ready"}, 32'(t_in_ready), 32'd1);
    @(negedge clk);
    t_in_valid = 1'b0;
    chk({nm, "_valid_e1"}, 32'(t_out_valid), 32'd0);
    @(negedge clk);
    chk({nm, "_valid_e2"}, 32'(t_out_valid), 32'd0);
    @(negedge clk);
    chk({nm, "_valid_e3"}, 32'(t_out_valid), 32'd1);
    chk({nm, "_posit"},    32'(t_out_posit), 32'(ep));
    chk({nm, "_inexact"},  32'(t_inex),      32'(ei));
    chk({nm, "_k_oob"},    32'(t_oob),       32'(eo));
  endtask

  task automatic run_reset(input bit s);
    logic [15:0] ep;
    bit ei, eo;
    sel = s;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      t_sign = 1'b0; t_te = s ? 70 : 7; t_frac = 32'h1234_5678; t_cut = 1'b0; t_rnd = 1'b0;
      t_zero = 1'b0; t_nar = 1'b0; t_in_valid = 1'b1; t_out_ready = 1'b1;
    end
    @(negedge clk);
    t_in_valid = 1'b0;
    #1 chk("rst_pre_valid", 32'(t_out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_valid",    32'(t_out_valid), 32'd0);
    chk("rst_posit",    32'(t_out_posit), 32'd0);
    chk("rst_inexact",  32'(t_inex),      32'd0);
    chk("rst_k_oob",    32'(t_oob),       32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_in_ready", 32'(t_in_ready), 32'd1);
    if (s) model(16, 2, 32, 1'b1, 9, 32'hA5A5_0000, 1'b0, 1'b0, 1'b0, 1'b0, ep, ei, eo);
    else   model(8, 0, 16, 1'b1, 2, 32'h0000_A5A5, 1'b0, 1'b0, 1'b0, 1'b0, ep, ei, eo);
    run_beat(1'b1, s ? 9 : 2, s ? 32'hA5A5_0000 : 32'h0000_A5A5, 1'b0, 1'b0, 1'b0, 1'b0,
             ep, ei, eo, "post_rst");
  endtask

  task automatic run_stream(input bit s, input int nb);
    exp_t        q[$];
    exp_t        ex;
    logic [15:0] ep, hp;
    bit          ei, eo, hi, ho, acc, prev_stall;
    int          sent, got, cyc;
    sel = s; sent = 0; got = 0; cyc = 0; acc = 1'b0; prev_stall = 1'b0;
    hp = '0; hi = 1'b0; ho = 1'b0;
    t_in_valid = 1'b0;
    while (got < nb && cyc < 20 * nb + 100) begin
      @(negedge clk);
      cyc++;
      if (acc) t_in_valid = 1'b0;
      t_out_ready = ($urandom_range(0, 2) != 0);
      if (!t_in_valid && sent < nb && $urandom_range(0, 3) != 0) begin
        t_sign = 1'($urandom_range(0, 1));
        t_te   = s ? int'($urandom_range(0, 140)) - 70 : int'($urandom_range(0, 18)) - 9;
        t_frac = $urandom;
        if ($urandom_range(0, 2) == 0) t_frac = t_frac & (s ? 32'hFFF0_0000 : 32'h0000_FC00);
        t_cut  = ($urandom_range(0, 3) == 0);
        t_rnd  = 1'($urandom_range(0, 1));
        t_zero = ($urandom_range(0, 11) == 0);
        t_nar  = ($urandom_range(0, 11) == 0);
        t_in_valid = 1'b1;
      end
      #1;
      chk("stream_in_ready", 32'(t_in_ready), 32'(!t_out_valid || t_out_ready));
      if (prev_stall) begin
        chk("stream_hold_valid", 32'(t_out_valid), 32'd1);
        chk("stream_hold_posit", 32'(t_out_posit), 32'(hp));
        chk("stream_hold_flags", {30'd0, t_inex, t_oob}, {30'd0, hi, ho});
      end
      if (t_out_valid && t_out_ready) begin
        if (q.size() == 0) begin
          chk("stream_spurious_beat", 32'd1, 32'd0);
        end else begin
          ex = q.pop_front();
          chk("stream_posit",   32'(t_out_posit), 32'(ex.p));
          chk("stream_inexact", 32'(t_inex),      32'(ex.inex));
          chk("stream_k_oob",   32'(t_oob),       32'(ex.oob));
        end
        got++;
      end
      acc = t_in_valid && t_in_ready;
      if (acc) begin
        if (s) model(16, 2, 32, t_sign, int'(t_te), t_frac, t_cut, t_rnd, t_zero, t_nar, ep, ei, eo);
        else   model(8, 0, 16, t_sign, int'(t_te), t_frac, t_cut, t_rnd, t_zero, t_nar, ep, ei, eo);
        q.push_back('{p: ep, inex: ei, oob: eo});
        sent++;
      end
      prev_stall = t_out_valid && !t_out_ready;
      hp = t_out_posit; hi = t_inex; ho = t_oob;
    end
    if (got < nb) chk("stream_timeout_beats", 32'(got), 32'(nb));
    @(negedge clk);
    t_in_valid  = 1'b0;
    t_out_ready = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // sign, te, frac, cut, rnd, zero, nar -> posit, inexact, k_oob  (N=8, ES=0)
    tbl[0]  = '{0,  0, 32'h0000, 0, 0, 0, 0, 16'h40, 0, 0};
    tbl[1]  = '{0,  1, 32'h0000, 0, 0, 0, 0, 16'h60, 0, 0};
    tbl[2]  = '{1,  0, 32'h0000, 0, 0, 0, 0, 16'hC0, 0, 0};
    tbl[3]  = '{0,  0, 32'h0400, 0, 0, 0, 0, 16'h40, 1, 0};
    tbl[4]  = '{0,  0, 32'h0400, 1, 0, 0, 0, 16'h41, 1, 0};
    tbl[5]  = '{0,  0, 32'h0400, 0, 1, 0, 0, 16'h40, 1, 0};
    tbl[6]  = '{0,  0, 32'h0400, 1, 1, 0, 0, 16'h40, 1, 0};
    tbl[7]  = '{0,  7, 32'h0000, 0, 0, 0, 0, 16'h7F, 1, 1};
    tbl[8]  = '{0, -9, 32'h0000, 0, 0, 0, 0, 16'h01, 1, 1};
    tbl[9]  = '{0,  6, 32'hFFFF, 0, 0, 0, 0, 16'h7F, 1, 0};
    tbl[10] = '{0,  3, 32'h1234, 0, 0, 0, 1, 16'h80, 0, 0};
    tbl[11] = '{0,  3, 32'h1234, 0, 0, 1, 0, 16'h00, 0, 0};
    tbl[12] = '{0,  3, 32'h1234, 0, 0, 1, 1, 16'h80, 0, 0};
    tbl[13] = '{0, -6, 32'h0000, 0, 0, 0, 0, 16'h01, 0, 0};
    tbl[14] = '{0, -1, 32'h8000, 0, 0, 0, 0, 16'h30, 0, 0};
    tbl[15] = '{1,  7, 32'h0000, 0, 0, 0, 0, 16'h81, 1, 1};
    tbl[16] = '{0,  5, 32'hFFFF, 0, 0, 0, 0, 16'h7F, 1, 0};
    tbl[17] = '{1, -7, 32'h0000, 0, 0, 0, 0, 16'hFF, 1, 1};
    tbl[18] = '{0,  7, 32'h0000, 0, 0, 1, 0, 16'h00, 0, 0};
    tbl[19] = '{0,  0, 32'h0C00, 0, 0, 0, 0, 16'h42, 1, 0};
    tbl[20] = '{1,  0, 32'h0400, 1, 0, 0, 0, 16'hBF, 1, 0};
    tbl[21] = '{0,  0, 32'hFC00, 0, 0, 0, 0, 16'h60, 1, 0};

    rst = 1'b1; sel = 1'b0;
    t_in_valid = 1'b0; t_sign = 1'b0; t_cut = 1'b0; t_rnd = 1'b0; t_zero = 1'b0; t_nar = 1'b0;
    t_out_ready = 1'b1; t_te = 0; t_frac = '0;
    repeat (2) @(negedge clk);
    chk("reset_valid8",  32'(if8.out_valid),  32'd0);
    chk("reset_posit8",  32'(if8.out_posit),  32'd0);
    chk("reset_valid16", 32'(if16.out_valid), 32'd0);
    chk("reset_posit16", 32'(if16.out_posit), 32'd0);
    chk("reset_flags16", {30'd0, if16.out_inexact, if16.out_k_oob}, 32'd0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready8",  32'(if8.in_ready),  32'd1);
    chk("reset_in_ready16", 32'(if16.in_ready), 32'd1);

    for (int i = 0; i < 22; i++)
      run_beat(tbl[i].sign, tbl[i].te, tbl[i].frac, tbl[i].cut, tbl[i].rnd, tbl[i].zero,
               tbl[i].nar, tbl[i].p, tbl[i].inex, tbl[i].oob, $sformatf("vec%0d", i));

    run_reset(1'b0);
    run_reset(1'b1);
    run_stream(1'b0, 40);
    run_stream(1'b1, 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
